// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_unit
//  Description : Data-memory access unit between the core memory stage and a
//                word-organised DRAM without byte enables. Sub-word stores are
//                read-modify-write; loads are lane-extracted and extended;
//                misaligned accesses are rejected without touching memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int READ_LAT = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic                                   req_we,
    input  logic [ADDR_W-1:0]                      req_addr,
    input  logic [DATA_W-1:0]                      req_wdata,
    input  logic [2:0]                             load_type,
    input  logic [1:0]                             store_type,
    output logic                                   rsp_valid,
    output logic [DATA_W-1:0]                      rsp_rdata,
    output logic                                   rsp_misaligned,
    output logic                                   dram_re,
    output logic                                   dram_we,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]     dram_address,
    output logic [DATA_W-1:0]                      dram_datain,
    input  logic [DATA_W-1:0]                      dram_dataout
);

    localparam int NB         = DATA_W / 8;
    localparam int OFF_W      = $clog2(NB);
    localparam int WA_W       = ADDR_W - OFF_W;
    localparam int CNT_W      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);
    localparam bit   WORD_IS_32 = (DATA_W == 32);

    // Load/store type encodings (RISC-V funct3 style)
    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [1:0] ST_SB  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;

    // Access size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                mis_q, mis_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [1:0]          w_size;
    logic                w_uns;
    logic                w_mis;
    logic                w_full;
    logic [OFF_W+2:0]    w_shift;
    logic [DATA_W-1:0]   w_rd_sh;
    logic [DATA_W-1:0]   w_rd_up;
    logic [6:0]          w_lsh;
    logic [DATA_W-1:0]   w_load;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_merge;

    // Decode size, signedness and alignment of the request on the input port
    always_comb begin
        w_size = SZ_W;
        w_uns  = 1'b0;
        if (req_we) begin
            case (store_type)
                ST_SB:   w_size = SZ_B;
                ST_SH:   w_size = SZ_H;
                default: w_size = SZ_W;
            endcase
        end else begin
            case (load_type)
                LD_LB:   w_size = SZ_B;
                LD_LBU:  begin w_size = SZ_B; w_uns = 1'b1; end
                LD_LH:   w_size = SZ_H;
                LD_LHU:  begin w_size = SZ_H; w_uns = 1'b1; end
                default: w_size = SZ_W;
            endcase
        end
        w_mis  = ((w_size == SZ_H) && req_addr[0]) ||
                 ((w_size == SZ_W) && (req_addr[1:0] != 2'b00));
        w_full = req_we && (w_size == SZ_W) && WORD_IS_32;
    end

    // Lane extraction/extension for loads and byte-lane merge for stores
    always_comb begin
        w_shift = {off_q, 3'b000};
        w_rd_sh = dram_dataout >> w_shift;
        case (size_q)
            SZ_B: begin
                w_lsh  = 7'(DATA_W - 8);
                w_mask = DATA_W'(8'hFF);
            end
            SZ_H: begin
                w_lsh  = 7'(DATA_W - 16);
                w_mask = DATA_W'(16'hFFFF);
            end
            default: begin
                w_lsh  = 7'(DATA_W - 32);
                w_mask = DATA_W'(32'hFFFF_FFFF);
            end
        endcase
        // Left-justify the lane, then shift back arithmetically or logically
        w_rd_up = w_rd_sh << w_lsh;
        w_load  = uns_q ? (w_rd_up >> w_lsh) : DATA_W'($signed(w_rd_up) >>> w_lsh);
        w_merge = (dram_dataout & ~(w_mask << w_shift)) |
                  ((wdata_q << w_shift) & (w_mask << w_shift));
    end

    // Next-state and datapath capture for the transaction sequencer
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = w_size;
                    uns_d   = w_uns;
                    mis_d   = w_mis;
                    off_d   = req_addr[OFF_W-1:0];
                    wdata_d = req_wdata;
                    addr_d  = req_addr[ADDR_W-1:OFF_W];
                    if (w_mis) begin
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (w_full) begin
                        din_d   = req_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        din_d   = w_merge;
                        state_d = S_WRITE;
                    end else begin
                        rdata_d = w_load;
                        state_d = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: begin
                rdata_d = '0;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured request fields, wait counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE) && !rst;
    assign dram_re        = (state_q == S_READ);
    assign dram_we        = (state_q == S_WRITE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_misaligned = (state_q == S_RESP) && mis_q;
    assign rsp_rdata      = rdata_q;
    assign dram_address   = addr_q;
    assign dram_datain    = din_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_unit
//  Description : Self-checking bench for dmem_access_unit (32-bit/READ_LAT=2
//                and 64-bit/READ_LAT=1 instances) against a byte-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit sel = 1'b0;

    // 32-bit instance signals
    logic        v32 = 0, we32 = 0;
    logic [10:0] a32 = 0;
    logic [31:0] wd32 = 0;
    logic [2:0]  lt32 = 0;
    logic [1:0]  st32 = 0;
    logic        rdy32, rv32, mis32, re32, dwe32;
    logic [31:0] rd32, din32, dout32;
    logic [8:0]  da32;

    // 64-bit instance signals
    logic        v64 = 0, we64 = 0;
    logic [10:0] a64 = 0;
    logic [63:0] wd64 = 0;
    logic [2:0]  lt64 = 0;
    logic [1:0]  st64 = 0;
    logic        rdy64, rv64, mis64, re64, dwe64;
    logic [63:0] rd64, din64, dout64;
    logic [7:0]  da64;

    dmem_access_unit #(.DATA_W(32), .ADDR_W(11), .READ_LAT(RL)) u_dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_we(we32),
        .req_addr(a32), .req_wdata(wd32), .load_type(lt32), .store_type(st32),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_misaligned(mis32),
        .dram_re(re32), .dram_we(dwe32), .dram_address(da32),
        .dram_datain(din32), .dram_dataout(dout32));

    dmem_access_unit #(.DATA_W(64), .ADDR_W(11), .READ_LAT(1)) u_dut64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_we(we64),
        .req_addr(a64), .req_wdata(wd64), .load_type(lt64), .store_type(st64),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_misaligned(mis64),
        .dram_re(re64), .dram_we(dwe64), .dram_address(da64),
        .dram_datain(din64), .dram_dataout(dout64));

    // DRAM models: word arrays, read pipelines, preload port
    logic [31:0] dram32 [0:511];
    logic [63:0] dram64 [0:255];
    logic [31:0] p32_0, p32_1;
    logic [63:0] p64_0;
    logic        pre_we = 0, pre_sel = 0;
    logic [8:0]  pre_addr = 0;
    logic [63:0] pre_data = 0;

    always @(posedge clk) begin
        if (pre_we && !pre_sel) dram32[pre_addr] <= pre_data[31:0];
        if (pre_we && pre_sel)  dram64[pre_addr[7:0]] <= pre_data;
        if (dwe32) dram32[da32] <= din32;
        if (dwe64) dram64[da64] <= din64;
        p32_0 <= re32 ? dram32[da32] : $urandom;
        p32_1 <= p32_0;
        p64_0 <= re64 ? dram64[da64] : {$urandom, $urandom};
    end
    assign dout32 = p32_1;
    assign dout64 = p64_0;

    // Views of whichever instance is under test
    logic        m_ready, m_rv, m_mis, m_re, m_we;
    logic [63:0] m_rd, m_din;
    logic [31:0] m_da;
    assign m_ready = sel ? rdy64 : rdy32;
    assign m_rv    = sel ? rv64  : rv32;
    assign m_mis   = sel ? mis64 : mis32;
    assign m_re    = sel ? re64  : re32;
    assign m_we    = sel ? dwe64 : dwe32;
    assign m_rd    = sel ? rd64  : {32'b0, rd32};
    assign m_din   = sel ? din64 : {32'b0, din32};
    assign m_da    = sel ? 32'(da64) : 32'(da32);

    // Byte-level reference memory for the 32-bit instance
    logic [7:0] rmem [0:2047];

    int          t_lat, t_nre, t_nwe, t_re_addr, t_we_addr;
    logic [63:0] t_rdata, t_wdat;
    bit          t_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit v, input bit we, input logic [10:0] a,
                         input logic [63:0] wd, input logic [2:0] lt, input logic [1:0] st);
        if (!sel) begin
            v32 = v; we32 = we; a32 = a; wd32 = wd[31:0]; lt32 = lt; st32 = st;
        end else begin
            v64 = v; we64 = we; a64 = a; wd64 = wd; lt64 = lt; st64 = st;
        end
    endtask

    task automatic preload(input bit w64, input int w, input logic [63:0] val);
        @(negedge clk);
        pre_sel = w64; pre_addr = 9'(w); pre_data = val; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        if (!w64) for (int i = 0; i < 4; i++) rmem[4*w+i] = val[8*i+:8];
    endtask

    // Issue one request and record strobes and the response
    task automatic txn(input bit we, input int addr, input logic [63:0] wd,
                       input logic [2:0] lt, input logic [1:0] st);
        t_lat = -1; t_nre = 0; t_nwe = 0; t_re_addr = -1; t_we_addr = -1;
        t_rdata = 0; t_wdat = 0; t_mis = 0;
        @(negedge clk);
        chk("ready_idle", m_ready, 1);
        drive(1, we, 11'(addr), wd, lt, st);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 40 && t_lat < 0; c++) begin
            @(negedge clk);
            if (m_re) begin t_nre++; t_re_addr = int'(m_da); end
            if (m_we) begin t_nwe++; t_we_addr = int'(m_da); t_wdat = m_din; end
            if (m_rv) begin t_lat = c; t_rdata = m_rd; t_mis = m_mis; end
        end
        @(negedge clk);
        chk("rsp_pulse_end", m_rv, 0);
        chk("ready_after_resp", m_ready, 1);
    endtask

    function automatic int size_of(input bit we, input logic [2:0] lt, input logic [1:0] st);
        if (we) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
        case (lt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [63:0] ref_word(input int w);
        return {32'b0, rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
    endfunction

    function automatic logic [63:0] ref_load(input int addr, input int sz, input bit uns);
        logic [63:0] v = 0;
        for (int i = 0; i < sz; i++) v |= 64'(rmem[addr+i]) << (8*i);
        if (!uns && v[8*sz-1]) v |= ~64'd0 << (8*sz);
        return v & 64'hFFFF_FFFF;
    endfunction

    // Run one 32-bit transaction and compare everything against the model
    task automatic check_txn32(input bit we, input int addr, input logic [31:0] wd,
                               input logic [2:0] lt, input logic [1:0] st);
        int sz, exp_lat, wa;
        bit misal, full, uns;
        logic [63:0] exp_rd;
        sz      = size_of(we, lt, st);
        uns     = !we && (lt == 3'd4 || lt == 3'd5);
        misal   = (addr % sz) != 0;
        full    = we && (sz == 4);
        wa      = addr / 4;
        exp_rd  = (!we && !misal) ? ref_load(addr, sz, uns) : 64'd0;
        if (we && !misal) for (int i = 0; i < sz; i++) rmem[addr+i] = wd[8*i+:8];
        exp_lat = misal ? 1 : (!we ? 2 + RL : (full ? 2 : 3 + RL));
        sel = 1'b0;
        txn(we, addr, {32'b0, wd}, lt, st);
        chk("latency", 64'(t_lat), 64'(exp_lat));
        chk("misaligned", t_mis, misal);
        chk("rdata", t_rdata, exp_rd);
        chk("re_count", 64'(t_nre), (misal || full) ? 64'd0 : 64'd1);
        chk("we_count", 64'(t_nwe), (we && !misal) ? 64'd1 : 64'd0);
        if (!misal) chk("word_addr", 64'(we ? t_we_addr : t_re_addr), 64'(wa));
        if (we && !misal) chk("write_word", t_wdat, ref_word(wa));
        chk("mem_word", {32'b0, dram32[wa]}, ref_word(wa));
    endtask

    initial begin
        int nwe_rst;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy32, 0);
        chk("rst_outs", {rv32, mis32, re32, dwe32}, 0);
        chk("rst_data", {rd32, din32}, 0);
        chk("rst_addr", da32, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", rdy32, 1);

        for (int w = 0; w < 32; w++) preload(0, w, {32'b0, $urandom});
        preload(0, 4, 64'h8899AABB);

        // Directed 32-bit sequence
        check_txn32(0, 'h13, 0, 3'd0, 0);
        chk("lb_value", t_rdata, 64'hFFFFFF88);
        chk("lb_addr", 64'(t_re_addr), 4);
        chk("lb_latency", 64'(t_lat), 4);
        check_txn32(0, 'h13, 0, 3'd4, 0);
        chk("lbu_value", t_rdata, 64'h88);
        check_txn32(1, 'h11, 32'h5C, 0, 2'd0);
        chk("sb_merge", t_wdat, 64'h88995CBB);
        chk("sb_latency", 64'(t_lat), 5);
        check_txn32(0, 'h10, 0, 3'd2, 0);
        chk("lw_after_sb", t_rdata, 64'h88995CBB);

        // Reset in the middle of a sub-word store (in READ)
        @(negedge clk);
        drive(1, 1, 11'h31, 64'hAB, 0, 2'd0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_in_read", re32, 1);
        chk("rdata_held", rd32, 32'h88995CBB);
        rst = 1'b1;
        #1;
        chk("abort_strobes", {re32, dwe32, rv32, mis32, rdy32}, 0);
        chk("abort_data", {rd32, din32, 23'b0, da32}, 0);
        nwe_rst = 0;
        repeat (2) begin @(negedge clk); if (dwe32) nwe_rst++; end
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_abort", rdy32, 1);
        repeat (6) begin @(negedge clk); if (dwe32) nwe_rst++; end
        chk("no_write_after_abort", 64'(nwe_rst), 0);
        chk("abort_mem", {32'b0, dram32[12]}, ref_word(12));

        check_txn32(1, 'h20, 32'hDEADBEEF, 0, 2'd2);
        chk("sw_addr", 64'(t_we_addr), 8);
        chk("sw_latency", 64'(t_lat), 2);
        check_txn32(0, 'h15, 0, 3'd1, 0);
        check_txn32(1, 'h22, 32'h1234, 0, 2'd2);
        check_txn32(0, 'h20, 0, 3'd3, 0);
        chk("undef_load_is_lw", t_rdata, 64'hDEADBEEF);
        check_txn32(1, 'h24, 32'hCAFEF00D, 0, 2'd3);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            check_txn32(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), $urandom,
                        3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        // 64-bit instance, READ_LAT=1
        preload(1, 0, 64'h0123456789ABCDEF);
        sel = 1'b1;
        txn(0, 'h04, 0, 3'd2, 0);
        chk("w64_lw", t_rdata, 64'h0000000001234567);
        chk("w64_lw_lat", 64'(t_lat), 3);
        txn(1, 'h06, 64'hFFFF, 0, 2'd1);
        chk("w64_sh_word", t_wdat, 64'hFFFF456789ABCDEF);
        chk("w64_sh_lat", 64'(t_lat), 4);
        chk("w64_sh_re", 64'(t_nre), 1);
        txn(0, 'h06, 0, 3'd1, 0);
        chk("w64_lh", t_rdata, 64'hFFFFFFFFFFFFFFFF);
        txn(0, 'h06, 0, 3'd5, 0);
        chk("w64_lhu", t_rdata, 64'h000000000000FFFF);
        txn(1, 'h04, 64'hCAFEF00D, 0, 2'd2);
        chk("w64_sw_rmw", t_wdat, 64'hCAFEF00D89ABCDEF);
        chk("w64_sw_lat", 64'(t_lat), 4);
        txn(0, 'h00, 0, 3'd0, 0);
        chk("w64_lb", t_rdata, 64'hFFFFFFFFFFFFFFEF);
        txn(0, 'h00, 0, 3'd2, 0);
        chk("w64_lw_sext", t_rdata, 64'hFFFFFFFF89ABCDEF);
        txn(0, 'h02, 0, 3'd2, 0);
        chk("w64_mis", t_mis, 1);
        chk("w64_mis_lat", 64'(t_lat), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
